pattern_queue: RTL and testbench

PATTERN_QUEUE -- requirements
Module: pattern_queue

---
 rtl/pattern_queue.sv | 115 +++++++++++
 tb/tb_pattern_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pattern_queue.sv
// Scrolling pattern queue: DEPTH rows of LANES-bit note patterns, shifted on STEP, cleared by player hits.
// Optional miss counter enabled by defining PATTERN_QUEUE_MISS_CNT_EN.
module pattern_queue #(
  parameter int LANES = 4,
  parameter int DEPTH = 8
) (
  input  logic                   C,
  input  logic                   INIT_N,
  input  logic                   STEP,
  input  logic                   LOAD,
  input  logic [LANES-1:0]       I,
  input  logic [LANES-1:0]       HIT,
  output logic [LANES-1:0]       O,
  output logic [LANES*DEPTH-1:0] ROWS,
  output logic                   HITOK,
  output logic                   EMPTY,
  output logic [15:0]            CNT,
  output logic [7:0]             MISS
);

  localparam logic [LANES-1:0] GEN_INIT = {1'b1, {(LANES-1){1'b0}}};

  logic [LANES-1:0]       rows_r [DEPTH];
  logic [LANES-1:0]       gen_r;
  logic                   hitok_r;
  logic [15:0]            cnt_r;
  logic [LANES-1:0]       bottom_s;
  logic [LANES-1:0]       gen_rot_s;
  logic [LANES*DEPTH-1:0] rows_flat_s;

  assign bottom_s  = rows_r[DEPTH-1];
  assign gen_rot_s = {gen_r[0], gen_r[LANES-1:1]};

  // Flatten the row array for the ROWS port; row 0 sits in the low bits
  always_comb begin
    rows_flat_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rows_flat_s[k*LANES +: LANES] = rows_r[k];
    end
  end

  // Row shift, hit clearing, generator rotation, hit pulse and step count
  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      for (int k = 0; k < DEPTH; k++) begin
        rows_r[k] <= '0;
      end
      gen_r   <= GEN_INIT;
      hitok_r <= 1'b0;
      cnt_r   <= 16'd0;
    end else begin
      hitok_r <= |(bottom_s & HIT);
      if (STEP) begin
        for (int k = 1; k < DEPTH; k++) begin
          rows_r[k] <= rows_r[k-1];
        end
        rows_r[0] <= LOAD ? I : gen_r;
        gen_r     <= LOAD ? gen_r : gen_rot_s;
        cnt_r     <= cnt_r + 16'd1;
      end else begin
        // A hit on the stationary bottom row removes the struck notes
        rows_r[DEPTH-1] <= bottom_s & ~HIT;
        gen_r           <= gen_r;
        cnt_r           <= cnt_r;
      end
    end
  end

`ifdef PATTERN_QUEUE_MISS_CNT_EN
  logic [7:0] miss_r;
  logic [8:0] miss_sum_s;
  logic [7:0] miss_next_s;

  function automatic logic [4:0] popcount(input logic [LANES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int j = 0; j < LANES; j++) begin
      c = c + 5'(v[j]);
    end
    return c;
  endfunction

  // Notes leaving the queue unhit are misses; the count saturates at 255
  always_comb begin
    miss_sum_s = {1'b0, miss_r} + 9'(popcount(bottom_s & ~HIT));
    if (miss_sum_s > 9'd255) begin
      miss_next_s = 8'd255;
    end else begin
      miss_next_s = miss_sum_s[7:0];
    end
  end

  // Miss counter register
  always_ff @(posedge C or negedge INIT_N) begin
    if (!INIT_N) begin
      miss_r <= 8'd0;
    end else if (STEP) begin
      miss_r <= miss_next_s;
    end else begin
      miss_r <= miss_r;
    end
  end

  assign MISS = miss_r;
`else
  assign MISS = 8'd0;
`endif

  assign O     = rows_r[DEPTH-1];
  assign ROWS  = rows_flat_s;
  assign HITOK = hitok_r;
  assign EMPTY = ~|rows_flat_s;
  assign CNT   = cnt_r;

endmodule

// File: tb/tb_pattern_queue.sv
// Randomized bench for pattern_queue against a queue-based reference model, plus directed scenarios.
module tb_pattern_queue;
  localparam int LANES = 4;
  localparam int DEPTH = 8;

  logic                   C = 1'b0;
  logic                   INIT_N;
  logic                   STEP;
  logic                   LOAD;
  logic [LANES-1:0]       I;
  logic [LANES-1:0]       HIT;
  logic [LANES-1:0]       O;
  logic [LANES*DEPTH-1:0] ROWS;
  logic                   HITOK;
  logic                   EMPTY;
  logic [15:0]            CNT;
  logic [7:0]             MISS;

  pattern_queue #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .C(C), .INIT_N(INIT_N), .STEP(STEP), .LOAD(LOAD), .I(I), .HIT(HIT),
    .O(O), .ROWS(ROWS), .HITOK(HITOK), .EMPTY(EMPTY), .CNT(CNT), .MISS(MISS)
  );

  always #5 C = ~C;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [LANES-1:0] m_rows[$];
  int               m_gen_pos;
  int               m_cnt;
  int               m_miss;
  bit               m_hitok;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rows.delete();
    for (int k = 0; k < DEPTH; k++) m_rows.push_back('0);
    m_gen_pos = LANES - 1;
    m_cnt = 0;
    m_miss = 0;
    m_hitok = 0;
  endtask

  task automatic model_edge(input bit step, input bit load, input logic [LANES-1:0] i, input logic [LANES-1:0] hit);
    logic [LANES-1:0] bottom;
    logic [LANES-1:0] gen;
    bottom = m_rows[DEPTH-1];
    m_hitok = ((bottom & hit) != '0);
    if (step) begin
`ifdef PATTERN_QUEUE_MISS_CNT_EN
      m_miss = m_miss + $countones(bottom & ~hit);
      if (m_miss > 255) m_miss = 255;
`endif
      gen = '0;
      gen[m_gen_pos] = 1'b1;
      void'(m_rows.pop_back());
      m_rows.push_front(load ? i : gen);
      if (!load) m_gen_pos = (m_gen_pos + LANES - 1) % LANES;
      m_cnt = (m_cnt + 1) % 65536;
    end else begin
      m_rows[DEPTH-1] = bottom & ~hit;
    end
  endtask

  task automatic compare_all(input string tag);
    logic [LANES*DEPTH-1:0] exp_rows;
    exp_rows = '0;
    for (int k = 0; k < DEPTH; k++) exp_rows[k*LANES +: LANES] = m_rows[k];
    check_eq({tag, "_o"}, 64'(O), 64'(m_rows[DEPTH-1]));
    check_eq({tag, "_rows"}, 64'(ROWS), 64'(exp_rows));
    check_eq({tag, "_hitok"}, 64'(HITOK), 64'(m_hitok));
    check_eq({tag, "_empty"}, 64'(EMPTY), 64'(exp_rows == '0));
    check_eq({tag, "_cnt"}, 64'(CNT), 64'(m_cnt));
    check_eq({tag, "_miss"}, 64'(MISS), 64'(m_miss));
  endtask

  // one clock cycle: drive on the falling edge, update model at the rising edge, compare just after
  task automatic cycle(input bit step, input bit load, input logic [LANES-1:0] i,
                       input logic [LANES-1:0] hit, input bit do_chk);
    @(negedge C);
    INIT_N = 1'b1;
    STEP = step; LOAD = load; I = i; HIT = hit;
    @(posedge C);
    model_edge(step, load, i, hit);
    #1;
    if (do_chk) compare_all("cyc");
  endtask

  // asynchronous reset asserted between edges; outputs must clear immediately
  task automatic async_reset(input string tag);
    @(negedge C);
    #2;
    INIT_N = 1'b0;
    #1;
    check_eq({tag, "_rst_o"}, 64'(O), 64'd0);
    check_eq({tag, "_rst_rows"}, 64'(ROWS), 64'd0);
    check_eq({tag, "_rst_hitok"}, 64'(HITOK), 64'd0);
    check_eq({tag, "_rst_cnt"}, 64'(CNT), 64'd0);
    check_eq({tag, "_rst_miss"}, 64'(MISS), 64'd0);
    check_eq({tag, "_rst_empty"}, 64'(EMPTY), 64'd1);
    model_reset();
  endtask

  initial begin
    INIT_N = 1'b0; STEP = 1'b0; LOAD = 1'b0; I = '0; HIT = '0;
    model_reset();
    #12;
    check_eq("por_rows", 64'(ROWS), 64'd0);
    check_eq("por_empty", 64'(EMPTY), 64'd1);

    // four generator steps from reset
    for (int n = 0; n < 4; n++) cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_eq("r31_rows", 64'(ROWS[15:0]), 64'h8421);
    check_eq("r31_empty", 64'(EMPTY), 64'd0);
    check_eq("r31_cnt", 64'(CNT), 64'd4);

    // latency of a loaded row, then hits on the bottom row
    async_reset("r32");
    cycle(1'b1, 1'b1, 4'b1010, '0, 1'b1);
    for (int n = 0; n < 7; n++) cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_eq("r32_o", 64'(O), 64'b1010);
    check_eq("r32_row0", 64'(ROWS[3:0]), 64'b0010);
    cycle(1'b0, 1'b0, '0, 4'b1000, 1'b1);
    check_eq("r33_o", 64'(O), 64'b0010);
    check_eq("r33_hitok", 64'(HITOK), 64'd1);
    cycle(1'b0, 1'b0, '0, 4'b0101, 1'b1);
    check_eq("r33_o_nohit", 64'(O), 64'b0010);
    check_eq("r33_hitok_nohit", 64'(HITOK), 64'd0);

    // reset mid-stream, then STEP held in the release cycle inserts the one-hot MSB
    async_reset("r35");
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_eq("r35_row0", 64'(ROWS[3:0]), 64'b1000);

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) async_reset("rnd");
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 1'b1);
    end

    // counter wrap after 65536 steps from reset
    async_reset("r36");
    for (int n = 0; n < 65535; n++) cycle(1'b1, 1'b0, '0, '0, 1'b0);
    compare_all("r36_ffff");
    check_eq("r36_cnt_ffff", 64'(CNT), 64'hFFFF);
    cycle(1'b1, 1'b0, '0, '0, 1'b1);
    check_eq("r36_cnt_wrap", 64'(CNT), 64'd0);
`ifdef PATTERN_QUEUE_MISS_CNT_EN
    check_eq("r34_miss_sat", 64'(MISS), 64'd255);
`else
    check_eq("r34_miss_off", 64'(MISS), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
